reg_text_composer: RTL and testbench

REG_TEXT_COMPOSER -- requirements
Module: reg_text_composer

---
 rtl/reg_text_composer.sv | 144 ++++++++++++++
 tb/tb_reg_text_composer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_text_composer.sv
// Formats one register as "Rnn=HHHHHHHH<term>" into a shadow buffer, one byte per clock,
// then publishes it to the display word on the next vertical-sync falling edge.
module reg_text_composer #(
  parameter logic [7:0] TERM_CHAR = 8'h3B
) (
  input  logic          iVGA_CLK,
  input  logic          iRST,
  input  logic          cVS,
  input  logic          start,
  input  logic [4:0]    reg_index,
  input  logic [31:0]   reg_value,
  output logic [0:103]  word,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    WAIT_VS = 2'd2
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [3:0]    cnt_r;
  logic [4:0]    idx_r;
  logic [31:0]   val_r;
  logic [0:103]  shadow_r;
  logic          cvs_d_r;
  logic          vs_fall_s;
  logic          accept_s;
  logic          emit_s;
  logic          commit_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n <= 4'd9) begin
      hex_char = 8'h30 + {4'd0, n};
    end else begin
      hex_char = 8'h41 + {4'd0, n - 4'd10};
    end
  endfunction

  // Character at text position pos: "R", two decimal digits, "=", eight hex nibbles MSB first, terminator.
  function automatic logic [7:0] compose_char(input logic [3:0] pos, input logic [4:0] idx,
                                              input logic [31:0] val);
    logic [4:0] tens;
    logic [4:0] ones;
    logic [2:0] nib_sel;
    tens    = idx / 5'd10;
    ones    = idx % 5'd10;
    nib_sel = 3'(4'd11 - pos);
    case (pos)
      4'd0:    compose_char = 8'h52;
      4'd1:    compose_char = 8'h30 + {3'd0, tens};
      4'd2:    compose_char = 8'h30 + {3'd0, ones};
      4'd3:    compose_char = 8'h3D;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
               compose_char = hex_char(val[{nib_sel, 2'b00} +: 4]);
      4'd12:   compose_char = TERM_CHAR;
      default: compose_char = 8'h00;
    endcase
  endfunction

  assign vs_fall_s = cvs_d_r & ~cVS;

  // State register.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle action decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    emit_s       = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = EMIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      EMIT: begin
        emit_s = 1'b1;
        if (cnt_r == 4'd12) begin
          next_state_s = WAIT_VS;
        end else begin
          next_state_s = EMIT;
        end
      end
      WAIT_VS: begin
        if (vs_fall_s) begin
          commit_s     = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_VS;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand capture, shadow fill, commit to the visible word, and sync edge history.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      cnt_r    <= 4'd0;
      idx_r    <= 5'd0;
      val_r    <= 32'd0;
      shadow_r <= '0;
      word     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cvs_d_r  <= 1'b1;
    end else begin
      cvs_d_r <= cVS;
      done    <= commit_s;
      if (accept_s) begin
        idx_r <= reg_index;
        val_r <= reg_value;
        cnt_r <= 4'd0;
        busy  <= 1'b1;
      end
      if (emit_s) begin
        shadow_r[{cnt_r, 3'b000} +: 8] <= compose_char(cnt_r, idx_r, val_r);
        cnt_r                          <= cnt_r + 4'd1;
      end
      // Only the fully built shadow ever reaches the screen.
      if (commit_s) begin
        word <= shadow_r;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_text_composer.sv
// Randomized/directed bench for reg_text_composer with a queue-based scoreboard
// and a separate monitor that checks every done pulse.
module tb_reg_text_composer;

  logic          clk = 1'b0;
  logic          rst;
  logic          cvs;
  logic          start;
  logic [4:0]    reg_index;
  logic [31:0]   reg_value;
  logic [0:103]  word;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [0:103] w;
    int           at;
  } exp_t;
  exp_t sb[$];

  reg_text_composer dut (
    .iVGA_CLK (clk),
    .iRST     (rst),
    .cVS      (cvs),
    .start    (start),
    .reg_index(reg_index),
    .reg_value(reg_value),
    .word     (word),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference text: table lookup of digit glyphs, built straight from the text format.
  function automatic logic [0:103] exp_word(input int idx, input logic [31:0] val);
    logic [0:103] w;
    string hx;
    hx = "0123456789ABCDEF";
    w[0 +: 8]  = 8'h52;
    w[8 +: 8]  = hx[idx / 10];
    w[16 +: 8] = hx[idx % 10];
    w[24 +: 8] = 8'h3D;
    for (int k = 0; k < 8; k++) begin
      w[32 + 8*k +: 8] = hx[int'((val >> (28 - 4*k)) & 32'hF)];
    end
    w[96 +: 8] = 8'h3B;
    return w;
  endfunction

  task automatic chk(input string name, input logic [103:0] got, input logic [103:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // One request: cVS low on edges [fall1,rise1) and [fall2,fall2+3); commit expected at exp_edge.
  task automatic run_req(input int idx, input logic [31:0] val, input int fall1, input int rise1,
                         input int fall2, input int exp_edge, input int extra_start_at,
                         input bit commit_start);
    int c0;
    @(negedge clk);
    start     = 1'b1;
    reg_index = 5'(idx);
    reg_value = val;
    c0        = cyc + 1;
    sb.push_back('{w: exp_word(idx, val), at: c0 + exp_edge});
    for (int e = 1; e <= fall2 + 5; e++) begin
      @(negedge clk);
      chk("busy_track", {103'd0, busy}, {103'd0, ((e - 1) < exp_edge)});
      start = 1'b0;
      if (e == 1) begin
        reg_index = 5'($urandom_range(0, 31));
        reg_value = $urandom;
      end
      if (e == extra_start_at) begin
        start     = 1'b1;
        reg_index = 5'd9;
        reg_value = $urandom;
      end
      if (commit_start && e == exp_edge) begin
        start     = 1'b1;
        reg_index = 5'($urandom_range(0, 31));
      end
      cvs = !((e >= fall1 && e < rise1) || (e >= fall2 && e < fall2 + 3));
    end
    start = 1'b0;
    cvs   = 1'b1;
    chk("commit_seen", 104'(sb.size()), 104'd0);
    while (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    int f1;
    int r1;
    int f2;
    rst       = 1'b1;
    cvs       = 1'b1;
    start     = 1'b1;
    reg_index = 5'd4;
    reg_value = 32'h1234_5678;

    // Monitor: every done pulse must match the head of the scoreboard.
    fork
      begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
          @(negedge clk);
          if (done) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_done: got done=1 expected no commit (cycle %0d)", cyc);
            end else begin
              exp_t x;
              x = sb.pop_front();
              chk("commit_word", word, x.w);
              chk("commit_cycle", 104'(cyc), 104'(x.at));
              chk("busy_at_done", {103'd0, busy}, 104'd0);
            end
            chk("done_width", {103'd0, prev_done}, 104'd0);
          end
          prev_done = done;
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_word", word, 104'd0);
    chk("reset_busy", {103'd0, busy}, 104'd0);
    chk("reset_done", {103'd0, done}, 104'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_reset_idle", {103'd0, busy}, 104'd0);

    run_req(7, 32'h0000_002A, 0, 0, 20, 20, 0, 1'b0);
    chk("word_hold_r07", word, exp_word(7, 32'h0000_002A));
    run_req(31, 32'hDEAD_BEEF, 0, 0, 14, 14, 0, 1'b1);
    run_req(3, 32'hCAFE_0103, 0, 0, 16, 16, 5, 1'b0);
    run_req(12, 32'h89AB_CDEF, 5, 30, 400, 400, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      f1 = 0;
      r1 = 0;
      if (t % 2 == 1) begin
        f1 = $urandom_range(1, 12);
        r1 = f1 + $urandom_range(1, 20);
      end
      f2 = ((r1 + 1 > 14) ? r1 + 1 : 14) + $urandom_range(0, 10);
      run_req($urandom_range(0, 31), $urandom, f1, r1, f2, f2, 0, 1'b0);
    end

    run_req(1, 32'h0000_0001, 0, 0, 15, 15, 0, 1'b0);
    chk("word_before_abort", word, exp_word(1, 32'h0000_0001));
    @(negedge clk);
    start     = 1'b1;
    reg_index = 5'd2;
    reg_value = 32'h0000_0002;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    chk("busy_in_wait_vs", {103'd0, busy}, 104'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_word", word, 104'd0);
    chk("abort_busy", {103'd0, busy}, 104'd0);
    chk("abort_done", {103'd0, done}, 104'd0);
    for (int i = 0; i < 30; i++) begin
      cvs = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    cvs = 1'b1;
    @(negedge clk);
    chk("post_abort_word", word, 104'd0);
    chk("post_abort_busy", {103'd0, busy}, 104'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
